// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment bus reader.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Index is the nibble the pattern represents.
   localparam logic [6:0] SEG_CODES [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      COLLECT,
      FULL
   } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex-to-seven-segment encoder.
// Unknown patterns, including blank, yield nibble 0 with legal low.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = '0;
      legal  = 1'b0;
      if (pattern != SEG_BLANK) begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_CODES[i]) begin
               nibble = 4'(i);
               legal  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seg7_reader.sv
// Samples a scanned seven-segment bus, debounces each digit, decodes it and
// assembles one nibble per digit into a word handed off via valid/ready.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     digit_sel,
   output logic [4*DIGITS-1:0]   word,
   output logic [DIGITS-1:0]     err_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   logic [DIGITS+6:0]   sample_q, sample_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*DIGITS-1:0] word_q, word_d;
   logic [DIGITS-1:0]   err_q, err_d;
   logic [DIGITS-1:0]   flags_q, flags_d;
   logic                overrun_q, overrun_d;
   state_e              state_q, state_d;

   logic       one_hot, same, capture, accept, legal;
   logic [3:0] nibble;

   seg7_decode u_decode (
      .pattern (seg_in),
      .nibble  (nibble),
      .legal   (legal)
   );

   always_comb begin
      sample_d  = {digit_sel, seg_in};
      one_hot   = $onehot(digit_sel);
      same      = ({digit_sel, seg_in} == sample_q);
      cnt_d     = cnt_q;
      word_d    = word_q;
      err_d     = err_q;
      overrun_d = overrun_q;

      if (!one_hot)
         cnt_d = '0;
      else if (!same)
         cnt_d = CW'(1);
      else if (cnt_q != CW'(STABLE_CYCLES))
         cnt_d = cnt_q + 1'b1;

      // Fires only on the step into saturation, so a held pattern captures once.
      capture = one_hot && same && (cnt_q == CW'(STABLE_CYCLES - 1));
      accept  = (state_q == FULL) && out_ready;

      // Acceptance clears flags first so a same-edge capture seeds the next frame.
      flags_d = accept ? '0 : flags_q;
      if (capture) begin
         if ((state_q == FULL) && !accept) begin
            overrun_d = 1'b1;
         end else begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (digit_sel[i]) begin
                  word_d[4*i +: 4] = nibble;
                  err_d[i]         = !legal;
                  flags_d[i]       = 1'b1;
               end
            end
         end
      end

      state_d = (flags_d == '1) ? FULL : COLLECT;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sample_q  <= '0;
         cnt_q     <= '0;
         word_q    <= '0;
         err_q     <= '0;
         flags_q   <= '0;
         overrun_q <= 1'b0;
         state_q   <= COLLECT;
      end else begin
         sample_q  <= sample_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         err_q     <= err_d;
         flags_q   <= flags_d;
         overrun_q <= overrun_d;
         state_q   <= state_d;
      end
   end

   assign word      = word_q;
   assign err_mask  = err_q;
   assign out_valid = (state_q == FULL);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Randomised and directed bench for seg7_reader against a run-length based
// behavioural model of the scanned-display reader.
module tb_seg7_reader;

   localparam int DIGITS = 4;
   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [6:0]  seg_in = 7'h7F;
   logic [3:0]  digit_sel = '0;
   logic [15:0] word;
   logic [3:0]  err_mask;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        overrun;

   seg7_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .seg_in    (seg_in),
      .digit_sel (digit_sel),
      .word      (word),
      .err_mask  (err_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   logic [6:0] codes [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int tests = 0;
   int fails = 0;
   bit checking = 1'b0;
   int valid_cnt = 0;
   logic [15:0] seen_word;
   logic [3:0]  seen_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [3:0]  m_nib [DIGITS];
   bit          m_err [DIGITS];
   int          m_flags, m_run, m_idx, m_code;
   bit          m_valid, m_ovr, m_cap, m_acc;
   logic [10:0] m_prev, m_cur;

   function automatic int lookup(input logic [6:0] p);
      for (int i = 0; i < 16; i++) if (codes[i] == p) return i;
      return -1;
   endfunction

   function automatic logic [15:0] m_word();
      logic [15:0] w;
      for (int i = 0; i < DIGITS; i++) w[4*i +: 4] = m_nib[i];
      return w;
   endfunction

   function automatic logic [3:0] m_errs();
      logic [3:0] e;
      for (int i = 0; i < DIGITS; i++) e[i] = m_err[i];
      return e;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DIGITS; i++) begin m_nib[i] = '0; m_err[i] = 1'b0; end
         m_flags = 0; m_run = 0; m_prev = '0; m_valid = 1'b0; m_ovr = 1'b0;
      end else begin
         m_cur = {digit_sel, seg_in};
         if ($countones(digit_sel) != 1) m_run = 0;
         else if (m_cur == m_prev)       m_run = m_run + 1;
         else                            m_run = 1;
         m_prev = m_cur;
         m_cap = (m_run == STABLE);
         m_acc = m_valid && out_ready;
         if (m_acc) begin m_flags = 0; m_valid = 1'b0; end
         if (m_cap) begin
            if (m_valid) m_ovr = 1'b1;
            else begin
               m_idx = $clog2(int'(digit_sel));
               m_code = lookup(seg_in);
               m_nib[m_idx] = (m_code < 0) ? 4'h0 : 4'(m_code);
               m_err[m_idx] = (m_code < 0);
               m_flags = m_flags | (1 << m_idx);
            end
         end
         if (m_flags == (1 << DIGITS) - 1) m_valid = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking && resetn) begin
         check("word", word, m_word());
         check("err_mask", err_mask, m_errs());
         check("out_valid", out_valid, m_valid);
         check("overrun", overrun, m_ovr);
         if (out_valid) begin
            valid_cnt++;
            seen_word = word;
            seen_err = err_mask;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int cycles, input bit rdy);
      digit_sel = sel;
      seg_in = seg;
      out_ready = rdy;
      repeat (cycles) begin @(posedge clk); #2; end
   endtask

   task automatic scan4(input int n0, input int n1, input int n2, input int n3, input bit rdy);
      drive(4'b0001, codes[n0], 6, rdy);
      drive(4'b0010, codes[n1], 6, rdy);
      drive(4'b0100, codes[n2], 6, rdy);
      drive(4'b1000, codes[n3], 6, rdy);
   endtask

   initial begin
      logic [3:0] rsel;
      logic [6:0] rseg;
      #1;
      check("reset_word", word, 16'h0);
      check("reset_valid", out_valid, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      resetn = 1'b1;
      checking = 1'b1;

      // stable capture
      valid_cnt = 0;
      scan4(1, 2, 3, 4, 1'b1);
      check("t1_valid_pulses", valid_cnt, 1);
      check("t1_seen_word", seen_word, 16'h4321);
      check("t1_seen_err", seen_err, 4'h0);
      check("t1_model_word", m_word(), 16'h4321);

      // illegal code in slot 2
      drive(4'b0001, codes[5], 6, 1'b1);
      drive(4'b0010, codes[6], 6, 1'b1);
      drive(4'b0100, 7'h7F, 6, 1'b1);
      drive(4'b1000, codes[8], 6, 1'b1);
      check("t3_word", word, 16'h8065);
      check("t3_err", err_mask, 4'b0100);
      check("t3_model_err", m_errs(), 4'b0100);

      // glitch rejection on digit 0
      drive(4'b0001, 7'h79, 2, 1'b1);
      drive(4'b0001, 7'h7F, 2, 1'b1);
      check("t2_no_blank_err", err_mask[0], 1'b0);
      check("t2_no_capture_yet", word[3:0], 4'h5);
      drive(4'b0001, 7'h79, 4, 1'b1);
      check("t2_nibble", word[3:0], 4'h1);
      check("t2_flags", dut.flags_q, 4'b0001);
      drive(4'b0010, codes[2], 6, 1'b1);
      drive(4'b0100, codes[3], 6, 1'b1);
      drive(4'b1000, codes[4], 6, 1'b1);

      // backpressure and overrun
      scan4(10, 11, 12, 13, 1'b0);
      drive(4'b0001, codes[0], 6, 1'b0);
      check("t4_frozen", word, 16'hDCBA);
      check("t4_valid", out_valid, 1'b1);
      check("t4_overrun", overrun, 1'b1);
      drive(4'b0001, codes[0], 1, 1'b1);
      check("t4_accepted", out_valid, 1'b0);
      scan4(9, 8, 7, 6, 1'b0);
      check("t4_rebuilt", word, 16'h6789);
      check("t4_valid2", out_valid, 1'b1);
      drive(4'b1000, codes[6], 1, 1'b1);

      // bad strobes
      drive(4'b0011, codes[1], 10, 1'b1);
      check("t5_cnt_multi", dut.cnt_q, 0);
      check("t5_flags_multi", dut.flags_q, 4'b0000);
      drive(4'b0000, codes[1], 10, 1'b1);
      check("t5_cnt_zero", dut.cnt_q, 0);
      check("t5_word_kept", word, 16'h6789);

      // reset mid-frame
      drive(4'b0001, codes[1], 6, 1'b1);
      drive(4'b0010, codes[2], 6, 1'b1);
      drive(4'b0100, codes[3], 6, 1'b1);
      check("t6_partial", dut.flags_q, 4'b0111);
      resetn = 1'b0;
      #1;
      check("t6_word", word, 16'h0);
      check("t6_err", err_mask, 4'h0);
      check("t6_valid", out_valid, 1'b0);
      check("t6_overrun", overrun, 1'b0);
      @(posedge clk); #1;
      resetn = 1'b1;
      drive(4'b1000, codes[4], 6, 1'b0);
      check("t6_no_frame", out_valid, 1'b0);
      scan4(1, 2, 3, 4, 1'b0);
      check("t6_rescan_valid", out_valid, 1'b1);
      check("t6_rescan_word", word, 16'h4321);
      drive(4'b1000, codes[4], 1, 1'b1);

      // randomised scanning
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            rsel = 4'($urandom_range(0, 15));
            if ($countones(rsel) == 1) rsel = 4'b0000;
         end else begin
            rsel = 4'b0001 << $urandom_range(0, 3);
         end
         if ($urandom_range(0, 4) == 0) rseg = 7'($urandom_range(0, 127));
         else rseg = codes[$urandom_range(0, 15)];
         drive(rsel, rseg, $urandom_range(1, 8), $urandom_range(0, 3) != 0);
      end

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Receive-side counterpart of the hex-to-seven-segment encoder. Samples a scanned, multiplexed seven-segment bus (active-low segment pattern plus a one-hot digit strobe) and filters out scan glitches. Decodes each stable pattern back to its 4-bit nibble and assembles one nibble per digit into a word. The word goes to downstream logic through a valid/ready handshake. Used for loopback self-check of the display path and for reading display-driving peripherals.

## Interface
- `DIGITS`, default 4: number of scanned digits; word width is 4*DIGITS.
- `STABLE_CYCLES`, default 4, minimum 2: consecutive identical samples required before a pattern is accepted.
- `clk` input, 1 bit: single clock; all state is updated on its rising edge.
- `resetn` input, 1 bit: asynchronous, active-low reset.
- `seg_in` input, 7 bits: active-low segments, bit0 = a … bit6 = g.
- `digit_sel` input, DIGITS bits: one-hot strobe naming the digit currently on `seg_in`.
- `word` output, 4*DIGITS bits: assembled nibbles, digit i at bits [4i+3:4i].
- `err_mask` output, DIGITS bits: bit i set when digit i's accepted pattern was not a legal code.
- `out_valid` output, 1 bit: `word` and `err_mask` hold a complete frame.
- `out_ready` input, 1 bit: consumer accepts the frame.
- `overrun` output, 1 bit: sticky; set when a capture is dropped while a frame is pending.

## Operation
- **Legal codes** (hex value of `seg_in` → nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 18→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
- **Illegal patterns:** every other pattern, including blank 7F. An illegal pattern decodes to nibble 0 with `err_mask` bit set.
- **Sample register:** holds {`digit_sel`, `seg_in`} from the previous edge.
- **Stability counter:**
  - Increments, saturating at STABLE_CYCLES, while the current inputs equal the sample register and `digit_sel` is one-hot.
  - Is set to 1 on any change.
  - Is set to 0 when `digit_sel` is zero or multi-hot.
- **Capture event:** happens on the edge where the counter steps from STABLE_CYCLES-1 to STABLE_CYCLES. It fires once per stable run; a held pattern does not re-fire.
- **Capture handling:**
  - Writes the decoded nibble and error bit into the slot selected by `digit_sel`.
  - Sets that digit's captured flag.
  - If the digit was already captured in the current frame, the newer value overwrites the old one.
- **Frame completion:** when all captured flags are set, `out_valid` asserts. Nibbles and `err_mask` then freeze until acceptance.
- **Acceptance:** `out_valid` and `out_ready` both high on an edge. All captured flags clear and `out_valid` deasserts.
- **Simultaneous capture and acceptance:** the capture is kept and counts toward the new frame.
- **Capture while `out_valid` is high and not accepted:** the capture is dropped and `overrun` is set.
- **`overrun`:** cleared only by reset.
- **FSM `state`:**
  - COLLECT → FULL when the last flag is set.
  - FULL → COLLECT on acceptance.

## Timing
- **Reset values:**
  - `word` = 0, `err_mask` = 0, `out_valid` = 0, `overrun` = 0.
  - Flags, sample register and counter cleared; FSM in COLLECT.
- **Reset mid-frame:** discards partial captures immediately; no frame is emitted.
- **Capture latency:** inputs held constant and one-hot for STABLE_CYCLES rising edges. The slot update is visible after the STABLE_CYCLES-th edge.
- **`out_valid` timing:** rises after the same edge that captures the final missing digit, with no extra cycle.
- **Handshake:**
  - `word` and `err_mask` are stable while `out_valid` is high.
  - `out_valid` does not depend combinationally on `out_ready`.
  - At most one frame is accepted per cycle.
- **Glitch rejection:** a glitch shorter than STABLE_CYCLES edges never causes a capture.

## Structure
- **Package `seg7_pkg`:**
  - The 16 legal code constants.
  - A blank constant (7F).
  - The FSM state typedef (COLLECT, FULL).
- **Sub-module `seg7_decode`:** purely combinational. Maps a 7-bit pattern to {nibble, legal}, using the package constants.
- **Top-level contents:** sample register, stability counter, per-digit slots and flags, FSM.

## Test plan
- **Stable capture:** DIGITS=4, STABLE_CYCLES=4; scan 1,2,3,4 (digit_sel 0001…1000), each held 6 cycles, `out_ready`=1. Expect `word`=16'h4321, `err_mask`=0, and `out_valid` high exactly one cycle, after the 4th edge of digit 3.
- **Glitch rejection:** digit 0 holds 79 but drops to 7F for 2 cycles mid-hold, then returns to 79 for 4 cycles. Expect a single capture of nibble 1; the blank is never captured.
- **Illegal code:** digit 2 shows 7F, other digits show legal codes. Expect nibble 0 in slot 2 and `err_mask`=4'b0100.
- **Backpressure:** `out_ready`=0 after a frame completes, scanning continues. Expect `word` frozen and `overrun`=1. Raise `out_ready` for one cycle and expect the next frame to rebuild.
- **Bad strobe:** `digit_sel`=4'b0011 or 4'b0000 held for 10 cycles. Expect no capture and the counter held at 0.
- **Reset mid-frame:** reset asserted after 3 digits are captured. Expect all outputs 0 immediately; a full rescan is required before `out_valid` asserts.
